// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file geometry shared by the regfile, issue and write-back logic
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_S0   = 2'd1,
        GNT_S1   = 2'd2
    } wb_grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard for long-latency destinations
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [NREG-1:0]   busy,
    output logic              sb_err
);
    logic [NREG-1:0] busy_q, busy_d;
    logic            sb_err_q, sb_err_d;
    logic            same_clr;

    assign same_clr = clr_valid && (clr_addr == alloc_addr);

    // Clear first, then set, so a same-cycle alloc of the retiring register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid)
            busy_d[clr_addr] = 1'b0;
        if (alloc_valid && (alloc_addr != REG_ZERO))
            busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
        sb_err_d = alloc_valid && busy_q[alloc_addr] && !same_clr;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign busy   = busy_q;
    assign sb_err = sb_err_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates the single regfile write port between commit and long-latency write-back
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic [NREG-1:0]   busy,
    output logic              sb_err,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    wb_grant_e        grant;
    wb_req_t          win;
    logic             wr_en;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rf_wen_q;
    wb_req_t          rf_q;

    // Commit normally wins; s1 only takes the port once it has lost STARVE_LIMIT times running.
    always_comb begin
        grant = GNT_NONE;
        if (resetn) begin
            if (s1_valid && (!s0_valid || (starve_q == STARVE_MAX)))
                grant = GNT_S1;
            else if (s0_valid)
                grant = GNT_S0;
        end
    end

    assign s0_ready = (grant == GNT_S0);
    assign s1_ready = (grant == GNT_S1);

    always_comb begin
        starve_d = '0;
        if (s1_valid && !s1_ready)
            starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 1'b1;
    end

    always_comb begin
        win = '{addr: s0_addr, data: s0_data};
        if (grant == GNT_S1)
            win = '{addr: s1_addr, data: s1_data};
    end

    // Writes to r0 are handshaken but never reach the register file.
    assign wr_en = (grant != GNT_NONE) && (win.addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_q <= '0;
            rf_wen_q <= 1'b0;
            rf_q     <= '0;
        end else begin
            starve_q <= starve_d;
            rf_wen_q <= wr_en;
            if (wr_en)
                rf_q <= win;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_q.addr;
    assign rf_wdata = rf_q.data;

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .resetn      (resetn),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .clr_valid   (s1_ready),
        .clr_addr    (s1_addr),
        .busy        (busy),
        .sb_err      (sb_err)
    );
endmodule
